// File: rtl/relprime_pkg.sv
// Shared types and constants for the relprime job queue.
package relprime_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } rp_state_e;

  localparam int RP_WIDTH       = 16;
  localparam int RP_DECIMAL_TWO = 2;
  localparam int RP_DECIMAL_ONE = 1;

endpackage

// File: rtl/relprime_fifo.sv
// Operand FIFO: circular buffer with wrapping pointers and an occupancy count.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module relprime_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/relprime_job_queue.sv
// Job controller for the relprime core: queues operands, pulses start, collects results.
// Define RELPRIME_CYCLE_COUNT_EN to add res_cycles (START + WAIT cycles per job).
module relprime_job_queue
  import relprime_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 4,
  parameter int WIDTH        = RP_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  output logic [WIDTH-1:0] core_register_value,
  output logic [WIDTH-1:0] core_decimal_two,
  output logic [WIDTH-1:0] core_decimal_one,
  output logic             core_start,
  input  logic [WIDTH-1:0] core_out,
  input  logic             core_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_n,
  output logic [WIDTH-1:0] res_m
`ifdef RELPRIME_CYCLE_COUNT_EN
  ,
  output logic [31:0]      res_cycles
`endif
);

  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  rp_state_e        state, state_n;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [SCW-1:0]   st_cnt;
  logic             st_last, capture;

  assign core_decimal_two = WIDTH'(RP_DECIMAL_TWO);
  assign core_decimal_one = WIDTH'(RP_DECIMAL_ONE);

  // Ready is gated by reset so nothing is accepted in the reset cycle.
  assign in_ready  = !fifo_full && !RST;
  assign fifo_push = in_valid && in_ready;
  assign st_last   = (st_cnt == SCW'(START_CYCLES - 1));

  relprime_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(in_n),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    fifo_pop   = 1'b0;
    core_start = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = START;
        end
      end
      // core_done may still be stale from the previous job here, so it is ignored.
      START: begin
        core_start = 1'b1;
        if (st_last) state_n = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          capture = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      core_register_value <= '0;
      st_cnt              <= '0;
      res_valid           <= 1'b0;
      res_n               <= '0;
      res_m               <= '0;
    end else begin
      if (fifo_pop) core_register_value <= fifo_rdata;
      if (state == START && !st_last) st_cnt <= st_cnt + SCW'(1);
      else                            st_cnt <= '0;
      if (capture) begin
        res_valid <= 1'b1;
        res_n     <= core_register_value;
        res_m     <= core_out;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef RELPRIME_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;

  // The capture cycle itself is a WAIT cycle, hence the +1 on capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_cnt    <= '0;
      res_cycles <= '0;
    end else begin
      if (fifo_pop)                            cyc_cnt <= '0;
      else if (state == START || state == WAIT) cyc_cnt <= cyc_cnt + 32'd1;
      if (capture) res_cycles <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_relprime_job_queue.sv
// Randomized self-checking bench for relprime_job_queue with a behavioural core model.
module tb_relprime_job_queue;

  localparam int DEPTH        = 4;
  localparam int START_CYCLES = 4;
  localparam int WIDTH        = 16;
  localparam int DIR_N        = 12;

  // Results with a known answer, in delivery order, across the directed phases.
  int dir_n_tab [DIR_N] = '{5040, 4620, 36432, 25534, 4590, 5040,
                            4620, 36432, 25534, 4590, 5040, 5040};
  int dir_m_tab [DIR_N] = '{11, 13, 5, 3, 7, 11, 13, 5, 3, 7, 11, 11};

  logic             CLK = 1'b0;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] core_register_value;
  logic [WIDTH-1:0] core_decimal_two;
  logic [WIDTH-1:0] core_decimal_one;
  logic             core_start;
  logic [WIDTH-1:0] core_out;
  logic             core_done = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] res_m;
`ifdef RELPRIME_CYCLE_COUNT_EN
  logic [31:0]      res_cycles;
`endif

  relprime_job_queue #(
    .DEPTH(DEPTH),
    .START_CYCLES(START_CYCLES),
    .WIDTH(WIDTH)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_n               (in_n),
    .core_register_value(core_register_value),
    .core_decimal_two   (core_decimal_two),
    .core_decimal_one   (core_decimal_one),
    .core_start         (core_start),
    .core_out           (core_out),
    .core_done          (core_done),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_n              (res_n),
    .res_m              (res_m)
`ifdef RELPRIME_CYCLE_COUNT_EN
    ,
    .res_cycles         (res_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic int gcd(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic int relprime(input int n);
    for (int m = 2; m < 65536; m++) if (gcd(m, n) == 1) return m;
    return 0;
  endfunction

  // ---------------- core model ----------------
  logic             st_q = 1'b0;
  logic             c_act = 1'b0;
  int               c_lat = 0;
  int               lat_lo = 0;
  logic [WIDTH-1:0] c_m = '0;
  logic [WIDTH-1:0] c_junk = '0;

  // done stays high (stale) until one cycle into the next start; core_out is junk while not done.
  always @(posedge CLK) begin
    st_q   <= core_start;
    c_junk <= WIDTH'($urandom);
    if (RST) begin
      c_act <= 1'b0;
    end else if (core_start) begin
      core_done <= 1'b0;
      if (!st_q) begin
        c_m   <= WIDTH'(relprime(int'(core_register_value)));
        c_act <= 1'b1;
        c_lat <= lat_lo + int'($urandom_range(0, 6));
      end
    end else if (c_act) begin
      if (c_lat == 0) begin
        core_done <= 1'b1;
        c_act     <= 1'b0;
      end else begin
        c_lat <= c_lat - 1;
      end
    end
  end

  assign core_out = core_done ? c_m : c_junk;

  // ---------------- result consumer ----------------
  logic rr_mode = 1'b0;
  logic rdy_val = 1'b1;

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      res_ready = rr_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // ---------------- checker ----------------
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_results = 0;
  int          dir_idx = 0;
  int          exp_q[$];
  int          occ = 0;
  int          plen = 0;
  int          wait_cyc = 0;
  logic        acc_pend = 1'b0;
  logic        start_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic        waiting = 1'b0;
  logic        cap_pend = 1'b0;
  logic        idle = 1'b1;
  logic        exp_rise = 1'b0;
  logic        rv_prev = 1'b0;
  logic        rr_prev = 1'b0;
  logic        pinned = 1'b0;
  logic        final_req = 1'b0;
  logic        final_done = 1'b0;
  logic [WIDTH-1:0] cap_n = '0, cap_m = '0, hold_n = '0, hold_m = '0, job_reg = '0;
  int          cap_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : mon
    logic rose, fell, hs;
    int   e;
    rose = core_start && !start_prev;
    fell = !core_start && start_prev;
    hs   = res_valid && res_ready;

    if (!pinned) begin
      chk("model_5040", relprime(5040), 11);
      chk("model_36432", relprime(36432), 5);
      chk("model_4590", relprime(4590), 7);
      pinned = 1'b1;
    end

    chk("decimal_two", core_decimal_two, 2);
    chk("decimal_one", core_decimal_one, 1);

    if (RST) begin
      chk("in_ready_in_reset", in_ready, 0);
      if (rst_prev) begin
        chk("rst_core_start", core_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_n", res_n, 0);
        chk("rst_res_m", res_m, 0);
        chk("rst_core_reg", core_register_value, 0);
`ifdef RELPRIME_CYCLE_COUNT_EN
        chk("rst_res_cycles", res_cycles, 0);
`endif
      end
      occ = 0; acc_pend = 1'b0; exp_q.delete();
      waiting = 1'b0; cap_pend = 1'b0; idle = 1'b1; plen = 0; exp_rise = 1'b0;
    end else begin
      if (acc_pend) occ++;
      if (rose) occ--;
      acc_pend = 1'b0;

      chk("start_rise", rose, exp_rise);
      chk("in_ready", in_ready, occ != DEPTH);

      if (core_start) plen++;
      if (fell) begin
        if (!rst_prev) begin
          chk("start_len", plen, START_CYCLES);
          waiting  = 1'b1;
          wait_cyc = 0;
        end
        plen = 0;
      end

      if (rose) begin
        idle    = 1'b0;
        job_reg = core_register_value;
        if (exp_q.size() == 0) chk("reg_head_unexpected_job", 1, 0);
        else chk("reg_head", core_register_value, exp_q[0]);
      end
      if (core_start || waiting) chk("reg_stable", core_register_value, job_reg);

      if (cap_pend) begin
        chk("res_valid_rise", res_valid, 1);
        chk("res_n_capture", res_n, cap_n);
        chk("res_m_capture", res_m, cap_m);
`ifdef RELPRIME_CYCLE_COUNT_EN
        chk("res_cycles", res_cycles, cap_cyc);
`endif
        cap_pend = 1'b0;
      end else if (waiting || core_start || idle) begin
        chk("res_valid_low", res_valid, 0);
      end

      if (waiting) begin
        wait_cyc++;
        if (core_done) begin
          cap_n    = core_register_value;
          cap_m    = core_out;
          cap_cyc  = START_CYCLES + wait_cyc;
          waiting  = 1'b0;
          cap_pend = 1'b1;
        end
      end

      if (res_valid) chk("start_in_hold", core_start, 0);
      if (rv_prev && !rr_prev && !rst_prev) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_res_n", res_n, hold_n);
        chk("hold_res_m", res_m, hold_m);
      end

      if (hs) begin
        n_results++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", res_n, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_res_n", res_n, e);
          chk("sb_res_m", res_m, relprime(e));
        end
        if (dir_idx < DIR_N) begin
          chk("dir_res_n", res_n, dir_n_tab[dir_idx]);
          chk("dir_res_m", res_m, dir_m_tab[dir_idx]);
          dir_idx++;
        end
      end

      exp_rise = idle && (occ > 0);
      if (hs) idle = 1'b1;

      if (in_valid && in_ready) begin
        acc_pend = 1'b1;
        exp_q.push_back(int'(in_n));
      end

      if (final_req && !final_done) begin
        chk("sb_drained", exp_q.size(), 0);
        chk("dir_count", dir_idx, DIR_N);
        final_done = 1'b1;
      end
    end

    rv_prev    = res_valid;
    rr_prev    = res_ready;
    hold_n     = res_n;
    hold_m     = res_m;
    start_prev = core_start;
    rst_prev   = RST;
  end

  // ---------------- stimulus ----------------
  task automatic fatal_timeout(input string name);
    $display("FAIL %s: DUT event not seen within cycle budget", name);
    $fatal(1);
  endtask

  task automatic push(input logic [WIDTH-1:0] n);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_n     = n;
    @(negedge CLK);
    while (!in_ready) begin
      t++;
      if (t > 1000) fatal_timeout("push_wait_ready");
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int k);
    int t;
    t = 0;
    while (n_results < k) begin
      @(negedge CLK);
      t++;
      if (t > 3000) fatal_timeout("wait_results");
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  initial begin
    int t;
    RST = 1'b1; in_valid = 1'b0; in_n = '0;
    idle_cycles(3);
    RST = 1'b0;
    idle_cycles(2);

    // single job
    push(16'd5040);
    wait_results(1);
    idle_cycles(20);

    // burst of DEPTH operands back to back
    push(16'd4620); push(16'd36432); push(16'd25534); push(16'd4590);
    wait_results(5);
    idle_cycles(5);

    // full FIFO behind a stalled result, then 20 cycles of backpressure
    rdy_val = 1'b0;
    push(16'd5040);
    t = 0;
    while (!res_valid) begin
      @(negedge CLK); t++;
      if (t > 1000) fatal_timeout("wait_res_valid");
    end
    @(posedge CLK); #1;
    push(16'd4620); push(16'd36432); push(16'd25534); push(16'd4590);
    in_valid = 1'b1; in_n = 16'd5040;
    idle_cycles(20);
    rdy_val = 1'b1;
    push(16'd5040);
    wait_results(11);
    idle_cycles(5);

    // reset during WAIT drops the job; the next one completes normally
    lat_lo = 5;
    push(16'd4620);
    t = 0;
    while (!waiting) begin
      @(negedge CLK); t++;
      if (t > 1000) fatal_timeout("wait_core_wait");
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    idle_cycles(1);
    RST = 1'b0;
    lat_lo = 0;
    idle_cycles(2);
    push(16'd5040);
    wait_results(12);

    // randomized traffic with random consumer backpressure
    rr_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      push(WIDTH'($urandom_range(2, 65535)));
    end
    t = 0;
    while (exp_q.size() != 0) begin
      @(negedge CLK); t++;
      if (t > 5000) fatal_timeout("drain");
    end
    rr_mode = 1'b0;
    idle_cycles(5);

    final_req = 1'b1;
    t = 0;
    while (!final_done) begin
      @(negedge CLK); t++;
      if (t > 10) fatal_timeout("final_check");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/relprime_job_queue.md
Name: relprime_job_queue

Overview:
Upstream feeder and downstream collector for the relprime core (`top_level`). Buffers incoming 16-bit operands in a small FIFO and issues each one to the core with a fixed-width start pulse. Waits for the core's done flag, then captures the result and presents operand/result pairs on a valid/ready output. Replaces bench-driven sequencing with a reusable RTL job controller.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, ≥2.
- START_CYCLES, 4, number of CLK cycles `core_start` is held high per job; ≥1.
- WIDTH, 16, operand/result width.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  FIFO can accept; a transfer occurs when in_valid && in_ready.
- in_n  input  WIDTH  operand n.
- core_register_value  output  WIDTH  operand to core; held stable for the whole job.
- core_decimal_two  output  WIDTH  constant 2.
- core_decimal_one  output  WIDTH  constant 1.
- core_start  output  1  start pulse to core.
- core_out  input  WIDTH  core result.
- core_done  input  1  core relprime_out flag.
- res_valid  output  1  result pair available.
- res_ready  input  1  consumer accepts; a transfer occurs when res_valid && res_ready.
- res_n  output  WIDTH  operand of the completed job.
- res_m  output  WIDTH  smallest m relatively prime to n, as returned by the core.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1; core_start=0; core_register_value=0; res_valid=0; res_n=0; res_m=0; FIFO empty; FSM in IDLE.
- `core_decimal_two` and `core_decimal_one` are constant outputs; they are not affected by reset.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count.
  - in_ready = (count != DEPTH). When full, in_ready is 0 even in a cycle where the FSM pops.
  - A push and a pop in the same cycle leave count unchanged.
- IDLE: if FIFO is non-empty, pop the head into core_register_value and go to START. Otherwise stay in IDLE.
- START:
  - core_start=1 for exactly START_CYCLES cycles, counted with an internal counter.
  - core_register_value stays stable.
  - core_done is ignored in this state, because the core may still show a stale done from the previous job.
  - Then core_start=0 and go to WAIT.
- WAIT:
  - On the first cycle with core_done=1, register core_out into res_m and core_register_value into res_n, set res_valid=1, and go to HOLD.
  - There is no timeout.
- HOLD:
  - Stay while res_valid && !res_ready.
  - On the handshake, clear res_valid and go to IDLE.
  - Minimum gap between jobs is therefore 1 idle cycle.
  - The FIFO keeps accepting input during every state.
- Latency: operand accepted at cycle t (FIFO empty, FSM idle) → core_start rises at t+2.
- Result timing: res_valid rises 1 cycle after the first core_done sample in WAIT.
- RST mid-job:
  - All state is cleared and the FIFO contents are discarded.
  - core_start drops on the next edge.
  - A pending result is lost.
- core_done asserted in START or HOLD: no effect.

Optional Feature:
Macro `RELPRIME_CYCLE_COUNT_EN`.
- Defined:
  - Adds output `res_cycles` [31:0].
  - An internal counter clears when START is entered and increments every cycle through START and WAIT.
  - It is captured alongside res_m, so the value equals START_CYCLES plus the number of WAIT cycles.
  - `res_cycles` resets to 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package `relprime_pkg`:
  - FSM state enum {IDLE, START, WAIT, HOLD}.
  - Constants RP_WIDTH=16, RP_DECIMAL_TWO=2, RP_DECIMAL_ONE=1.
- One sub-module, `relprime_fifo`: parameterised DEPTH/WIDTH synchronous FIFO with push/pop/full/empty/count.
- FSM, start counter and result register live in `relprime_job_queue`.

Test Plan:
- Run against the real `top_level` core.
- Single job: push 5040, res_ready=1 → res_n=5040, res_m=11; core_start high exactly 4 cycles; exactly one result pair delivered.
- Burst: push 4620, 36432, 25534, 4590 back-to-back → in_ready stays high through all 4 pushes (DEPTH=4); results in order (4620,13), (36432,5), (25534,3), (4590,7).
- Full FIFO: with the FSM stalled in HOLD (res_ready=0), push 5 operands → 4 accepted while FIFO empty and the 5th stalled with in_ready=0 until a pop.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid → res_n and res_m stable and core_start stays 0 throughout; release → next job starts 2 cycles later.
- Reset mid-job: assert RST during WAIT for 4620 → res_valid=0, core_start=0, in_ready=1 after reset, FIFO empty; then push 5040 → result 11.
- RELPRIME_CYCLE_COUNT_EN build: push 5040 → res_cycles = START_CYCLES + WAIT cycles measured by the bench.
